// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encodings and default word width.
package uart_tx_arb_pkg;

    localparam int DEF_WORD_WIDTH = 8;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin pick: first set bit of req at or above ptr, wrapping modulo N.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         pick
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [2*N-1:0] dbl_fwd;
    logic [2*N-1:0] dbl_back;
    logic [N-1:0]   rot;
    logic [N-1:0]   rot_pick;

    // Rotate so ptr lands on bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        dbl_fwd  = {req, req} >> ptr;
        rot      = dbl_fwd[N-1:0];
        rot_pick = rot & (~rot + ONE);
        dbl_back = {rot_pick, rot_pick} << ptr;
        pick     = dbl_back[2*N-1:N];
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-locked round-robin arbiter sharing one UART transmit word interface among NREQ requesters.
// Optional holder-idle watchdog release is built when UART_ARB_WDOG_EN is defined.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
    parameter int NREQ        = 4,
    parameter int MAX_BURST   = 16,
    parameter int WDOG_CYCLES = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*WORD_WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]            req_last,
    output logic [NREQ-1:0]            req_ready,
    output logic                       wr_valid,
    output logic [WORD_WIDTH-1:0]      wr_data,
    input  logic                       wr_ready,
    output logic [NREQ-1:0]            grant,
    output logic                       wdog_err,
    output logic                       state_dbg
);

    localparam int PW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_t      state_q;
    logic [NREQ-1:0] grant_q;
    logic [PW-1:0]   rr_ptr_q;
    logic [PW-1:0]   rr_ptr_d;
    logic [BW-1:0]   beat_cnt_q;
    logic [PW-1:0]   g_idx;
    logic [NREQ-1:0] pick;
    logic            accept;
    logic            hit_last;
    logic            hit_cap;
    logic            wdog_fire;
    logic            release_any;

    rr_pick #(.N(NREQ)) u_pick (
        .req  (req_valid),
        .ptr  (rr_ptr_q),
        .pick (pick)
    );

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) g_idx = PW'(i);
        end
    end

    // Handshake: a beat moves when wr_valid && wr_ready; both sides are driven straight
    // from the registered grant, so grant_q == 0 in IDLE blocks every transfer.
    assign wr_valid  = |(grant_q & req_valid);
    assign wr_data   = req_data[g_idx*WORD_WIDTH +: WORD_WIDTH];
    assign req_ready = grant_q & {NREQ{wr_ready}};
    assign grant     = grant_q;
    assign state_dbg = (state_q == ARB_LOCKED);

    assign accept      = wr_valid & wr_ready;
    assign hit_last    = accept & req_last[g_idx];
    assign hit_cap     = accept & (beat_cnt_q == BW'(MAX_BURST - 1));
    assign release_any = hit_last | hit_cap | wdog_fire;
    assign rr_ptr_d    = (g_idx == PW'(NREQ - 1)) ? '0 : g_idx + PW'(1);

`ifdef UART_ARB_WDOG_EN
    localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    logic [WW-1:0] wdog_cnt_q;
    logic          wdog_err_q;

    assign wdog_fire = (state_q == ARB_LOCKED) && !wr_valid &&
                       (wdog_cnt_q == WW'(WDOG_CYCLES - 1));
    assign wdog_err  = wdog_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_err_q <= wdog_fire;
            if (state_q != ARB_LOCKED || wr_valid || wdog_fire) wdog_cnt_q <= '0;
            else                                               wdog_cnt_q <= wdog_cnt_q + WW'(1);
        end
    end
`else
    assign wdog_fire = 1'b0;
    assign wdog_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (|req_valid) begin
                        grant_q <= pick;
                        state_q <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (release_any) begin
                        state_q    <= ARB_IDLE;
                        grant_q    <= '0;
                        beat_cnt_q <= '0;
                        rr_ptr_q   <= rr_ptr_d;
                    end else if (accept) begin
                        beat_cnt_q <= beat_cnt_q + BW'(1);
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: reset, packet lock, round-robin order, burst cap, stall,
// watchdog release (UART_ARB_WDOG_EN builds only) and asynchronous reset mid-packet.
module tb_uart_tx_arb;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int MB = 16;
    localparam int WD = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           wr_valid;
    logic [W-1:0]   wr_data;
    logic           wr_ready;
    logic [N-1:0]   grant;
    logic           wdog_err;
    logic           state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_arb #(
        .WORD_WIDTH (W),
        .NREQ       (N),
        .MAX_BURST  (MB),
        .WDOG_CYCLES(WD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .grant     (grant),
        .wdog_err  (wdog_err),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive(input int i, input logic v, input logic [W-1:0] d, input logic l);
        req_valid[i]         = v;
        req_data[i*W +: W]   = d;
        req_last[i]          = l;
    endtask

    initial begin
        int n;
        int accepted;
        int idle_mid;
        logic acc_prev;

        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        wr_ready  = 1'b1;

        #3;
        chk("rst_grant",     32'(grant),     32'(4'b0000));
        chk("rst_wr_valid",  32'(wr_valid),  32'(1'b0));
        chk("rst_req_ready", 32'(req_ready), 32'(4'b0000));
        chk("rst_wdog_err",  32'(wdog_err),  32'(1'b0));
        chk("rst_state",     32'(state_dbg), 32'(1'b0));
        step(); step();
        rst_n = 1'b1;

        // Test 1: three-beat packet from requester 0
        drive(0, 1'b1, 8'hA1, 1'b0);
        settle();
        chk("t1_idle_grant", 32'(grant), 32'(4'b0000));
        chk("t1_idle_valid", 32'(wr_valid), 32'(1'b0));
        step(); settle();
        chk("t1_grant",     32'(grant),     32'(4'b0001));
        chk("t1_state",     32'(state_dbg), 32'(1'b1));
        chk("t1_wr_valid",  32'(wr_valid),  32'(1'b1));
        chk("t1_beat1",     32'(wr_data),   32'(8'hA1));
        chk("t1_req_ready", 32'(req_ready), 32'(4'b0001));
        step(); drive(0, 1'b1, 8'hA2, 1'b0); settle();
        chk("t1_beat2", 32'(wr_data), 32'(8'hA2));
        step(); drive(0, 1'b1, 8'hA3, 1'b1); settle();
        chk("t1_beat3", 32'(wr_data), 32'(8'hA3));
        chk("t1_grant_held", 32'(grant), 32'(4'b0001));
        step(); drive(0, 1'b0, 8'h00, 1'b0); settle();
        chk("t1_released", 32'(grant), 32'(4'b0000));
        chk("t1_state_idle", 32'(state_dbg), 32'(1'b0));

        // Test 2: all requesters, single-beat packets; rr_ptr is 1 after test 1
        step();
        for (int i = 0; i < N; i++) drive(i, 1'b1, 8'(8'h10 + i), 1'b1);
        settle();
        chk("t2_idle_start", 32'(grant), 32'(4'b0000));
        for (int k = 0; k < 8; k++) begin
            int e;
            e = (k + 1) % N;
            step(); settle();
            chk("t2_grant",     32'(grant),     32'(4'b0001 << e));
            chk("t2_data",      32'(wr_data),   32'(8'h10 + e));
            chk("t2_req_ready", 32'(req_ready), 32'(4'b0001 << e));
            step(); settle();
            chk("t2_idle_gap", 32'(grant), 32'(4'b0000));
        end
        req_valid = '0;
        req_last  = '0;

        // Test 3: 40-beat packet from requester 2, cap 16 beats; rr_ptr is 1
        step();
        n        = 1;
        accepted = 0;
        idle_mid = 0;
        drive(2, 1'b1, 8'(n), 1'b0);
        for (int c = 0; c < 60; c++) begin
            settle();
            acc_prev = wr_valid && wr_ready;
            if (acc_prev) begin
                chk("t3_data",  32'(wr_data), 32'(n));
                chk("t3_grant", 32'(grant),   32'(4'b0100));
                accepted++;
            end else if (n > 1) begin
                chk("t3_release_at", 32'(n), (idle_mid == 0) ? 32'd17 : 32'd33);
                idle_mid++;
            end
            step();
            if (acc_prev) n++;
            if (n > 40) begin
                drive(2, 1'b0, 8'h00, 1'b0);
                break;
            end
            drive(2, 1'b1, 8'(n), (n == 40));
        end
        chk("t3_accepted", 32'(accepted), 32'd40);
        chk("t3_releases", 32'(idle_mid), 32'd2);
        settle();
        chk("t3_final_idle", 32'(grant), 32'(4'b0000));

        // Test 4: holder stalled by wr_ready=0 for 5 cycles; rr_ptr is 3
        wr_ready = 1'b0;
        drive(0, 1'b1, 8'h55, 1'b0);
        step();
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("t4_stall_valid", 32'(wr_valid),  32'(1'b1));
            chk("t4_stall_data",  32'(wr_data),   32'(8'h55));
            chk("t4_stall_ready", 32'(req_ready), 32'(4'b0000));
            chk("t4_stall_grant", 32'(grant),     32'(4'b0001));
            step();
        end
        wr_ready = 1'b1;
        settle();
        chk("t4_ready", 32'(req_ready), 32'(4'b0001));
        chk("t4_data1", 32'(wr_data),   32'(8'h55));
        step(); drive(0, 1'b1, 8'h66, 1'b1); settle();
        chk("t4_data2", 32'(wr_data), 32'(8'h66));
        step(); drive(0, 1'b0, 8'h00, 1'b0); settle();
        chk("t4_idle", 32'(grant), 32'(4'b0000));

`ifdef UART_ARB_WDOG_EN
        // Test 5: holder 1 stalls mid-packet while requester 3 waits; rr_ptr is 1
        drive(1, 1'b1, 8'h77, 1'b0);
        drive(3, 1'b1, 8'hC3, 1'b1);
        step(); settle();
        chk("t5_grant1", 32'(grant),   32'(4'b0010));
        chk("t5_data",   32'(wr_data), 32'(8'h77));
        step(); drive(1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < WD; k++) begin
            settle();
            chk("t5_hold_grant", 32'(grant),    32'(4'b0010));
            chk("t5_no_err",     32'(wdog_err), 32'(1'b0));
            step();
        end
        settle();
        chk("t5_released", 32'(grant),    32'(4'b0000));
        chk("t5_err_pulse", 32'(wdog_err), 32'(1'b1));
        step(); settle();
        chk("t5_grant3",  32'(grant),    32'(4'b1000));
        chk("t5_err_end", 32'(wdog_err), 32'(1'b0));
        chk("t5_data3",   32'(wr_data),  32'(8'hC3));
        step(); drive(3, 1'b0, 8'h00, 1'b0); settle();
        chk("t5_idle", 32'(grant), 32'(4'b0000));
`else
        chk("t5_wdog_tied", 32'(wdog_err), 32'(1'b0));
`endif

        // Test 6: reset mid-packet; first move rr_ptr to 2 with a requester-1 packet
        drive(1, 1'b1, 8'h41, 1'b1);
        step(); settle();
        chk("t6_grant1", 32'(grant), 32'(4'b0010));
        step(); drive(1, 1'b0, 8'h00, 1'b0); settle();
        step();
        drive(0, 1'b1, 8'h31, 1'b0);
        step(); settle();
        chk("t6_grant0", 32'(grant), 32'(4'b0001));
        step();
        drive(0, 1'b1, 8'h32, 1'b0);
        wr_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_grant",     32'(grant),     32'(4'b0000));
        chk("t6_rst_wr_valid",  32'(wr_valid),  32'(1'b0));
        chk("t6_rst_req_ready", 32'(req_ready), 32'(4'b0000));
        step(); step();
        rst_n    = 1'b1;
        wr_ready = 1'b1;
        for (int i = 0; i < N; i++) drive(i, 1'b1, 8'(8'h20 + i), 1'b1);
        settle();
        chk("t6_idle", 32'(grant), 32'(4'b0000));
        step(); settle();
        chk("t6_restart_grant", 32'(grant),   32'(4'b0001));
        chk("t6_restart_data",  32'(wr_data), 32'(8'h20));
        step();
        req_valid = '0;
        req_last  = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
